// File: rtl/mips_control_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state names,
// opcode/funct constants, ALU operation codes and datapath select codes.
package mips_control_fsm_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States whose exit marks a completed instruction.
  function automatic logic is_retire_state(input state_e s);
    return s inside {MEMWB, MEMWR, RWB, BRANCH, JUMP, ADDIWB};
  endfunction

endpackage

// File: rtl/mips_control_fsm_alu_decoder.sv
// R-type funct field to ALU operation decoder; valid low for unsupported funct.
module alu_decoder
  import mips_control_fsm_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] aluop,
  output logic       valid
);

  always_comb begin
    aluop = ALU_ADD;
    valid = 1'b1;
    case (funct)
      FN_ADD:  aluop = ALU_ADD;
      FN_SUB:  aluop = ALU_SUB;
      FN_AND:  aluop = ALU_AND;
      FN_OR:   aluop = ALU_OR;
      FN_SLT:  aluop = ALU_SLT;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS control FSM: Moore-style datapath controls per state,
// funct-driven ALU op in EXEC, illegal-instruction pulse and retire counter.
module mips_control_fsm
  import mips_control_fsm_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic [3:0]       ALUop,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_dbg
);

  state_e     state, next_state;
  logic [3:0] dec_aluop;
  logic       dec_valid;

  alu_decoder u_alu_decoder (
    .funct (funct),
    .aluop (dec_aluop),
    .valid (dec_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (reset)                       retired <= '0;
    else if (is_retire_state(state)) retired <= retired + 1'b1;
  end

  assign state_dbg = state;

  always_comb begin
    next_state  = FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    PCSource    = PCSRC_ALU;
    ALUop       = ALU_ADD;
    illegal     = 1'b0;

    case (state)
      FETCH: begin
        MemRead    = 1'b1;
        IRWrite    = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        PCWrite    = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        ALUSrcB = SRCB_IMMSH;
        case (opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXEC;
          OP_BEQ:       next_state = BRANCH;
          OP_J:         next_state = JUMP;
          OP_ADDI:      next_state = ADDIEX;
          default: begin
            illegal    = 1'b1;
            next_state = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead    = 1'b1;
        IorD       = 1'b1;
        next_state = MEMWB;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_REG;
        if (dec_valid) begin
          ALUop      = dec_aluop;
          next_state = RWB;
        end else begin
          illegal = 1'b1;
        end
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_REG;
        ALUop       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        next_state = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
      end
      default: next_state = FETCH;
    endcase

    // Reset masks the outputs combinationally so nothing fires before the
    // state register has been forced back to FETCH.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_REG;
      PCSource    = PCSRC_ALU;
      ALUop       = ALU_ADD;
      illegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_control_fsm.sv
// Random instruction stream checked cycle by cycle against a per-instruction
// phase model of the control unit, plus a narrow-counter instance for wrap.
module tb_mips_control_fsm;
  import mips_control_fsm_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;

  logic        pcw, pcwc, iord, mr, mw, m2r, irw, rw, rd, asa, ill;
  logic [1:0]  asb, pcs;
  logic [3:0]  aop, sdbg;
  logic [31:0] ret;

  logic        pcw2, pcwc2, iord2, mr2, mw2, m2r2, irw2, rw2, rd2, asa2, ill2;
  logic [1:0]  asb2, pcs2;
  logic [3:0]  aop2, sdbg2;
  logic [2:0]  ret2;

  mips_control_fsm u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .PCWrite(pcw), .PCWriteCond(pcwc), .IorD(iord), .MemRead(mr),
    .MemWrite(mw), .MemtoReg(m2r), .IRWrite(irw), .RegWrite(rw),
    .RegDst(rd), .ALUSrcA(asa), .ALUSrcB(asb), .PCSource(pcs),
    .ALUop(aop), .illegal(ill), .retired(ret), .state_dbg(sdbg)
  );

  mips_control_fsm #(.CNT_W(3)) u_dut_w (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .PCWrite(pcw2), .PCWriteCond(pcwc2), .IorD(iord2), .MemRead(mr2),
    .MemWrite(mw2), .MemtoReg(m2r2), .IRWrite(irw2), .RegWrite(rw2),
    .RegDst(rd2), .ALUSrcA(asa2), .ALUSrcB(asb2), .PCSource(pcs2),
    .ALUop(aop2), .illegal(ill2), .retired(ret2), .state_dbg(sdbg2)
  );

  always #5 clk = ~clk;

  logic [18:0] ctrl1, ctrl2;
  assign ctrl1 = {pcw, pcwc, iord, mr, mw, m2r, irw, rw, rd, asa, asb, pcs, aop, ill};
  assign ctrl2 = {pcw2, pcwc2, iord2, mr2, mw2, m2r2, irw2, rw2, rd2, asa2, asb2, pcs2, aop2, ill2};

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned model_ret = 0;
  state_e      seq[$];
  bit          seq_retires;
  bit          rw_window = 1'b0;
  bit          rw_seen   = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (rw_window && (rw || rw2)) rw_seen = 1'b1;

  // ALU op for each supported funct; bit 4 flags a supported funct.
  function automatic logic [4:0] funct_op(input logic [5:0] fn);
    case (fn)
      6'b100000: return 5'b1_0010;
      6'b100010: return 5'b1_0110;
      6'b100100: return 5'b1_0000;
      6'b100101: return 5'b1_0001;
      6'b101010: return 5'b1_0111;
      default:   return 5'b0_0010;
    endcase
  endfunction

  // Control word expected in a given instruction phase.
  function automatic logic [18:0] exp_ctrl(input state_e s, input logic [5:0] op,
                                           input logic [5:0] fn, input bit rst);
    logic pw = 0, pwc = 0, ID = 0, MR = 0, MW = 0, M2R = 0, IRW = 0, RW = 0, RD = 0, SA = 0, IL = 0;
    logic [1:0] SB = 2'b00, PS = 2'b00;
    logic [3:0] AO = 4'b0010;
    logic [4:0] fo;
    if (!rst) begin
      case (s)
        FETCH:  begin MR = 1; IRW = 1; SB = 2'b01; pw = 1; end
        DECODE: begin
          SB = 2'b11;
          IL = !(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000});
        end
        MEMADR: begin SA = 1; SB = 2'b10; end
        MEMRD:  begin MR = 1; ID = 1; end
        MEMWB:  begin RW = 1; M2R = 1; end
        MEMWR:  begin MW = 1; ID = 1; end
        EXEC:   begin
          fo = funct_op(fn);
          SA = 1; AO = fo[3:0]; IL = !fo[4];
        end
        RWB:    begin RW = 1; RD = 1; end
        BRANCH: begin SA = 1; AO = 4'b0110; pwc = 1; PS = 2'b01; end
        JUMP:   begin pw = 1; PS = 2'b10; end
        ADDIEX: begin SA = 1; SB = 2'b10; end
        ADDIWB: begin RW = 1; end
        default: ;
      endcase
    end
    return {pw, pwc, ID, MR, MW, M2R, IRW, RW, RD, SA, SB, PS, AO, IL};
  endfunction

  // Phase list for one instruction, FETCH through its last state.
  task automatic build_seq(input logic [5:0] op, input logic [5:0] fn);
    logic [4:0] fo;
    seq = {FETCH, DECODE};
    seq_retires = 1'b1;
    case (op)
      6'b100011: seq = {seq, MEMADR, MEMRD, MEMWB};
      6'b101011: seq = {seq, MEMADR, MEMWR};
      6'b000100: seq.push_back(BRANCH);
      6'b000010: seq.push_back(JUMP);
      6'b001000: seq = {seq, ADDIEX, ADDIWB};
      6'b000000: begin
        fo = funct_op(fn);
        seq.push_back(EXEC);
        if (fo[4]) seq.push_back(RWB);
        else       seq_retires = 1'b0;
      end
      default: seq_retires = 1'b0;
    endcase
  endtask

  // Entered #1 after a rising edge with the DUT in FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
    build_seq(op, fn);
    opcode = op;
    funct  = fn;
    foreach (seq[i]) begin
      @(negedge clk);
      check_val("state", sdbg, seq[i]);
      check_val("ctrl", ctrl1, exp_ctrl(seq[i], op, fn, 1'b0));
      check_val("ctrl_w", ctrl2, exp_ctrl(seq[i], op, fn, 1'b0));
      @(posedge clk); #1;
    end
    if (seq_retires) model_ret++;
    check_val("retired", ret, model_ret);
    check_val("retired_w", ret2, model_ret % 8);
  endtask

  initial begin
    logic [5:0] op, fn;
    logic [5:0] fn_list [5];
    fn_list = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    reset = 1'b1; opcode = 6'b000000; funct = 6'b000000;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("rst_ctrl", ctrl1, exp_ctrl(FETCH, opcode, funct, 1'b1));
    @(posedge clk); #1;
    check_val("rst_state", sdbg, FETCH);
    check_val("rst_retired", ret, 0);
    check_val("rst_retired_w", ret2, 0);
    reset = 1'b0;

    run_instr(6'b000000, 6'b100010);
    run_instr(6'b100011, 6'b010101);
    run_instr(6'b000100, 6'b000000);
    run_instr(6'b111111, 6'b100000);
    run_instr(6'b000000, 6'b000000);
    run_instr(6'b101011, 6'b111000);
    run_instr(6'b000010, 6'b000001);
    run_instr(6'b001000, 6'b100010);

    for (int i = 0; i < 150; i++) begin
      fn = 6'($urandom);
      case ($urandom_range(0, 7))
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: begin op = 6'b000000; fn = fn_list[$urandom_range(0, 4)]; end
        3: op = 6'b000000;
        4: op = 6'b000100;
        5: op = 6'b000010;
        6: op = 6'b001000;
        default: op = 6'($urandom);
      endcase
      run_instr(op, fn);
    end

    // Abort a load in MEMRD: no write-back may occur and nothing retires.
    opcode = 6'b100011; funct = 6'b000000;
    rw_window = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check_val("mid_state", sdbg, MEMRD);
    reset = 1'b1;
    #1;
    check_val("mid_rst_ctrl", ctrl1, exp_ctrl(MEMRD, opcode, funct, 1'b1));
    @(posedge clk); #1;
    check_val("mid_rst_state", sdbg, FETCH);
    check_val("mid_rst_retired", ret, 0);
    check_val("mid_rst_retired_w", ret2, 0);
    reset = 1'b0;
    model_ret = 0;
    repeat (3) begin @(posedge clk); #1; end
    check_val("mid_rst_no_regwrite", rw_seen, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rw_window = 1'b0;

    for (int i = 0; i < 20; i++) run_instr(6'b000000, fn_list[i % 5]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_control_fsm.md
MIPS_CONTROL_FSM -- requirements
Module: mips_control_fsm

Interface
REQ-001 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 opcode  in  6  IR[31:26], held stable by the datapath after Fetch.
REQ-005 funct  in  6  IR[5:0], held stable by the datapath after Fetch.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA  out  1 each  datapath enables and mux selects.
REQ-007 ALUSrcB  out  2  B-operand select: 00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-008 PCSource  out  2  PC mux select: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-009 ALUop  out  4  drives the ALU ALUop port directly: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
REQ-010 illegal  out  1  one-cycle pulse on an unsupported opcode or funct.
REQ-011 retired  out  CNT_W  count of completed instructions.
REQ-012 state_dbg  out  4  current state encoding.

Function
REQ-013 The FSM SHALL implement states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, JUMP, ADDIEX, ADDIWB.
REQ-014 FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUop=0010, PCSource=00, PCWrite=1; next DECODE.
REQ-015 DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=0010 (branch target); next by opcode: 100011/101011->MEMADR, 000000->EXEC, 000100->BRANCH, 000010->JUMP, 001000->ADDIEX, other->FETCH with illegal=1.
REQ-016 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=0010; lw->MEMRD, sw->MEMWR.
REQ-017 MEMRD: MemRead=1, IorD=1; next MEMWB. MEMWB: RegWrite=1, RegDst=0, MemtoReg=1; next FETCH.
REQ-018 MEMWR: MemWrite=1, IorD=1; next FETCH.
REQ-019 EXEC: ALUSrcA=1, ALUSrcB=00, ALUop from funct: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111; next RWB; unsupported funct -> FETCH with illegal=1, no RegWrite.
REQ-020 RWB: RegWrite=1, RegDst=1, MemtoReg=0; next FETCH.
REQ-021 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=0110, PCWriteCond=1, PCSource=01; next FETCH.
REQ-022 JUMP: PCWrite=1, PCSource=10; next FETCH.
REQ-023 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUop=0010; next ADDIWB. ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; next FETCH.
REQ-024 Every output not listed for a state SHALL be 0; ALUop defaults to 0010.
REQ-025 Outputs SHALL be combinational from state (and funct in EXEC only); no output depends on opcode outside DECODE/MEMADR.
REQ-026 Cycle counts FETCH-to-FETCH SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
REQ-027 retired SHALL increment by 1 on the edge leaving MEMWB, MEMWR, RWB, BRANCH, JUMP, ADDIWB; it SHALL not increment on illegal; it wraps modulo 2^CNT_W.

Reset
REQ-028 With reset high at a rising edge, state SHALL become FETCH and retired SHALL become 0, regardless of current state (reset mid-instruction aborts it without retiring).
REQ-029 While reset is high, PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite and illegal SHALL be forced 0, ALUop=0010, all selects 0.
REQ-030 The first edge after reset deassertion SHALL perform FETCH.

Structure
REQ-031 A shared package SHALL hold the state enumeration, opcode constants, funct constants and ALUop codes, shared with the ALU and its bench.
REQ-032 The funct-to-ALUop mapping SHALL be one sub-module, alu_decoder (funct in, ALUop and valid out).

Verification
REQ-033 reset 2 cycles, opcode=000000 funct=100010 -> states FETCH,DECODE,EXEC(ALUop=0110),RWB(RegWrite=1,RegDst=1),FETCH; retired=1.
REQ-034 opcode=100011 -> 5 cycles, MEMRD MemRead=1 IorD=1, MEMWB MemtoReg=1 RegWrite=1; retired increments.
REQ-035 opcode=000100 -> BRANCH with ALUop=0110, PCWriteCond=1, PCSource=01, PCWrite=0; back to FETCH after 3 cycles.
REQ-036 opcode=111111 -> illegal=1 for exactly one cycle in DECODE, FETCH next, retired unchanged.
REQ-037 reset asserted in MEMRD -> next cycle state=FETCH, retired=0, no RegWrite pulse ever seen.
REQ-038 R-type funct=000000 -> illegal pulse in EXEC, RegWrite stays 0, FETCH next.
